// File: rtl/xnor_cmp_arbiter.sv
// Round-robin arbiter sharing one 1-bit XNOR stage between two requesters.
// Each grant compares the winner's captured operands bit-serially over W cycles.
module xnor_cmp_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic         eq,
  output logic         xnor_bit
);

  localparam int unsigned     CntW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic            last_id_q, last_id_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            done_q, done_d;
  logic            done_id_q, done_id_d;
  logic            eq_q, eq_d;

  logic bit_xnor;
  logic win_id;

  // The one shared comparison stage.
  assign bit_xnor = ~(sa_q[0] ^ sb_q[0]);

  // On a tie the requester that did not win last time goes next.
  assign win_id = (req0 & req1) ? ~last_id_q : req1;

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    last_id_d = last_id_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    done_d    = done_q;
    done_id_d = done_id_q;
    eq_d      = eq_q;
    case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          state_d   = StRun;
          sa_d      = win_id ? a1 : a0;
          sb_d      = win_id ? b1 : b0;
          cnt_d     = '0;
          acc_d     = 1'b1;
          gnt0_d    = ~win_id;
          gnt1_d    = win_id;
          done_id_d = win_id;
          last_id_d = win_id;
        end
      end
      StRun: begin
        acc_d = acc_q & bit_xnor;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        // No early exit: every operation takes exactly W serial steps.
        if (cnt_q == CntLast) begin
          state_d = StDone;
          eq_d    = acc_q & bit_xnor;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b1;
      last_id_q <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      last_id_q <= last_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      eq_q      <= eq_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign eq       = eq_q;
  assign busy     = (state_q == StRun) | (state_q == StDone);
  assign xnor_bit = (state_q == StRun) & bit_xnor;

endmodule

// File: tb/tb_xnor_cmp_arbiter.sv
// Directed bench for xnor_cmp_arbiter: W=8 instance plus a W=1 instance,
// expected {done_id, eq} pairs queued at stimulus time and popped on done.
module tb_xnor_cmp_arbiter;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, busy, done, done_id, eq, xnor_bit;

  logic       s_req0 = 1'b0, s_req1 = 1'b0;
  logic [0:0] s_a0 = '0, s_b0 = '0, s_a1 = '0, s_b1 = '0;
  logic       s_gnt0, s_gnt1, s_busy, s_done, s_done_id, s_eq, s_xnor_bit;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, overlap = 0, done_cyc = 0;
  logic [1:0] sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (gnt0 && gnt1) overlap <= overlap + 1;
  end

  xnor_cmp_arbiter #(.W(8)) u_dut (
    .clk(clk), .areset(areset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .eq(eq), .xnor_bit(xnor_bit)
  );

  xnor_cmp_arbiter #(.W(1)) u_dut_w1 (
    .clk(clk), .areset(areset),
    .req0(s_req0), .a0(s_a0), .b0(s_b0),
    .req1(s_req1), .a1(s_a1), .b1(s_b1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .busy(s_busy), .done(s_done),
    .done_id(s_done_id), .eq(s_eq), .xnor_bit(s_xnor_bit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done, counting negedges from 'start'; checks latency when exp_lat > 0.
  task automatic wait_done(input string tag, input int start, input int exp_lat);
    int         lat;
    bit         seen;
    logic [1:0] e;
    lat  = start;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      done_cyc = cyc;
      if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({tag, "_done_id"}, 32'(done_id), 32'(e[1]));
        chk({tag, "_eq"}, 32'(eq), 32'(e[0]));
      end
      @(negedge clk);
      chk({tag, "_after_done"}, {29'd0, done, gnt0, gnt1}, 32'd0);
    end
  endtask

  initial begin
    int prev_cyc;
    int cnt_before;
    int lat;
    bit seen;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", {25'd0, gnt0, gnt1, busy, done, done_id, eq, xnor_bit}, 32'd0);
    chk("reset_outputs_w1", {25'd0, s_gnt0, s_gnt1, s_busy, s_done, s_done_id, s_eq,
                             s_xnor_bit}, 32'd0);
    areset = 1'b0;

    // Requester 0 alone, equal operands
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'hA5;
    sb_q.push_back(2'b01);
    @(negedge clk);
    chk("t1_grant", {29'd0, gnt0, gnt1, busy}, 32'b101);
    chk("t1_xnor_bit", 32'(xnor_bit), 32'd1);
    req0 = 1'b0;
    wait_done("t1", 1, 9);

    // Requester 1 alone, MSB-only mismatch
    req1 = 1'b1; a1 = 8'h80; b1 = 8'h00;
    sb_q.push_back(2'b10);
    @(negedge clk);
    chk("t2_grant", {30'd0, gnt0, gnt1}, 32'b01);
    req1 = 1'b0;
    wait_done("t2", 1, 9);

    // Requester 0, bit 0 mismatch
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h00;
    sb_q.push_back(2'b00);
    @(negedge clk);
    chk("t3_xnor_bit", 32'(xnor_bit), 32'd0);
    req0 = 1'b0;
    wait_done("t3", 1, 9);

    // Both held: last winner was 0, so order is 1,0,1,0 from here
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h5A; b0 = 8'h5A; a1 = 8'hC3; b1 = 8'hC3;
    sb_q.push_back(2'b11); sb_q.push_back(2'b01);
    sb_q.push_back(2'b11); sb_q.push_back(2'b01);
    wait_done("t4_0", 0, 9);
    for (int k = 1; k < 4; k++) begin
      prev_cyc = done_cyc;
      wait_done($sformatf("t4_%0d", k), 0, 0);
      chk($sformatf("t4_spacing_%0d", k), done_cyc - prev_cyc, 10);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t4_no_overlap", overlap, 0);

    // Grant to 0 so last_id=0, then reset mid-RUN
    req0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
    @(negedge clk);
    chk("t5_grant", {30'd0, gnt0, gnt1}, 32'b10);
    req0 = 1'b0;
    cnt_before = done_cnt;
    repeat (3) @(posedge clk);
    #2 areset = 1'b1;
    #1 chk("t5_async_clear", {25'd0, gnt0, gnt1, busy, done, done_id, eq, xnor_bit}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_held_clear", {25'd0, gnt0, gnt1, busy, done, done_id, eq, xnor_bit}, 32'd0);
    areset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h11; b0 = 8'h11; a1 = 8'h01; b1 = 8'h00;
    sb_q.push_back(2'b01);
    @(negedge clk);
    chk("t5_first_after_reset", {30'd0, gnt0, gnt1}, 32'b10);
    req0 = 1'b0; req1 = 1'b0;
    wait_done("t5", 1, 9);
    chk("t5_single_done", done_cnt - cnt_before, 1);

    // Inputs changed and request dropped mid-RUN
    req0 = 1'b1; a0 = 8'h3C; b0 = 8'h3C;
    sb_q.push_back(2'b01);
    @(negedge clk);
    chk("t6_grant", 32'(gnt0), 32'd1);
    @(negedge clk);
    a0 = 8'hFF; req0 = 1'b0;
    wait_done("t6", 2, 9);
    chk("sb_drained", sb_q.size(), 0);
    chk("no_overlap_final", overlap, 0);

    // W=1 instance: a0=1, b0=0
    s_req0 = 1'b1; s_a0 = 1'b1; s_b0 = 1'b0;
    lat  = 0;
    seen = 1'b0;
    @(negedge clk);
    lat++;
    chk("w1_grant", {29'd0, s_gnt0, s_gnt1, s_xnor_bit}, 32'b100);
    s_req0 = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (s_done) seen = 1'b1;
    end
    chk("w1_done_seen", 32'(seen), 32'd1);
    chk("w1_latency", lat, 2);
    chk("w1_eq_id", {30'd0, s_eq, s_done_id}, 32'b00);
    @(negedge clk);
    chk("w1_after_done", {29'd0, s_done, s_gnt0, s_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
